mac_sequencer: RTL
==================

Name: mac_sequencer

Overview:
Controller that sequences one shared combinational multiply-accumulate unit (weight*value+cumulative, int8 saturating or fp8 mode) through an N-element dot product. It accepts weight/value pairs over a valid/ready stream and feeds each pair to the MAC. It registers the MAC output as the running accumulator, then presents the final result and a sticky overflow flag through a result handshake. It sits between the operand fetch logic and the MAC datapath.

Parameters:
LEN_W, 6, width of the element-count input; maximum dot-product length is 2^LEN_W-1
DATA_W, 8, operand/result width; must match the MAC datapath (8)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin a dot product; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE next cycle from any state
float_mode  input  1  0=int8, 1=fp8; latched on accepted start
length  input  LEN_W  number of pairs; latched on accepted start
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer accepts pair this cycle
in_weight  input  DATA_W  weight operand
in_value  input  DATA_W  value operand
mult_weight  output  DATA_W  to MAC weight (pass-through of in_weight)
mult_value  output  DATA_W  to MAC value (pass-through of in_value)
mult_cumulative  output  DATA_W  to MAC cumulative (accumulator register)
mult_float  output  1  to MAC float select (latched mode)
mult_out  input  DATA_W  MAC result
mult_overflow  input  1  MAC overflow/saturation flag
busy  output  1  high in RUN or DONE
result_valid  output  1  result available
result_ready  input  1  consumer takes result
result  output  DATA_W  final accumulator
result_overflow  output  1  OR of mult_overflow over all accepted beats

Behaviour:
- States: IDLE, RUN, DONE. Reset → IDLE. acc=0, count=0, mode=0, ovf_sticky=0. All outputs 0.
- IDLE: in_ready=0, busy=0. start=1 with abort=0 latches mode/length, clears acc (0x00 = int 0 / fp8 +0), count and ovf_sticky. Next state is RUN, or DONE if length==0.
- RUN: in_ready=1, busy=1. A beat is accepted when in_valid&in_ready. On accept: acc<=mult_out; ovf_sticky|=mult_overflow; count<=count+1. If count==length-1, next state is DONE.
- No beat accepted → acc/count hold. Stall cycles are unlimited.
- DONE: in_ready=0, result_valid=1, result=acc, result_overflow=ovf_sticky. All hold stable until result_ready=1, then IDLE the next cycle.
- Latency: start at cycle T → in_ready=1 at T+1. Last beat accepted at cycle K → result_valid=1 at K+1. Back-to-back: a new start is accepted the cycle after the IDLE return.
- The MAC path is purely combinational within a cycle: mult_cumulative=acc, mult_float=mode, mult_weight/value=in_weight/in_value in all states. The MAC is driven with no gating; only the acc update is gated.
- start outside IDLE is ignored. Mode/length changes after start have no effect.
- abort: highest priority. Any state → IDLE next cycle; acc/count/ovf cleared; result_valid drops; no beat is accepted in the abort cycle. abort+start in IDLE → stay IDLE.
- Reset mid-operation: immediate return to IDLE with reset values; no result is produced.
- Count arithmetic is LEN_W bits unsigned; it never wraps because length ≤ 2^LEN_W-1.

Optional Feature:
MAC_SEQ_STALL_CNT_EN:
- Defined: adds output stall_count[15:0], counting RUN cycles with in_valid=0. Cleared on accepted start, saturates at 0xFFFF, held through DONE/IDLE, cleared by abort/reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Int, length=3, pairs (0x02,0x03),(0x04,0xFF),(0x05,0x05), in_valid every cycle → result=0x1B, result_overflow=0, result_valid 4 cycles after start.
- Int overflow, length=2, pairs (0x7F,0x02),(0x00,0x00) → MAC saturates. result=0x7F, result_overflow=1 (sticky across second beat).
- Fp8, length=2, pairs (0x38,0x40),(0x40,0x40): 1.0*2.0 + 2.0*2.0 → result=0x4C (6.0), mult_float=1 during RUN.
- length=0 start → result_valid=1 one cycle after start, result=0x00. Hold result_ready=0 for 5 cycles → result/result_valid stable. result_ready=1 → IDLE next cycle.
- Stall/abort: length=4, in_valid toggled 1,0,0,1; abort after 2 beats → IDLE next cycle, result_valid never asserted. Start with stall_count (if enabled) = 2 before abort.
- Reset asserted asynchronously mid-RUN → outputs 0 immediately. The next start produces a correct, independent result.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequences a shared combinational MAC through an N-element dot product.
// Optional MAC_SEQ_STALL_CNT_EN adds a RUN-cycle input-stall counter output.
`timescale 1ns/1ps
module mac_sequencer #(
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              float_mode,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] in_value,
    output logic [DATA_W-1:0] mult_weight,
    output logic [DATA_W-1:0] mult_value,
    output logic [DATA_W-1:0] mult_cumulative,
    output logic              mult_float,
    input  logic [DATA_W-1:0] mult_out,
    input  logic              mult_overflow,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_overflow
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   len_q;
    logic               mode;
    logic               ovf_sticky;

    // The MAC sees operands every cycle; only the accumulator update is gated.
    assign mult_weight     = in_weight;
    assign mult_value      = in_value;
    assign mult_cumulative = acc;
    assign mult_float      = mode;
    assign result          = acc;
    assign result_overflow = ovf_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            len_q        <= '0;
            mode         <= 1'b0;
            ovf_sticky   <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_count  <= 16'd0;
`endif
        end else if (abort) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            ovf_sticky   <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_count  <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode       <= float_mode;
                        len_q      <= length;
                        acc        <= '0;
                        count      <= '0;
                        ovf_sticky <= 1'b0;
                        busy       <= 1'b1;
`ifdef MAC_SEQ_STALL_CNT_EN
                        stall_count <= 16'd0;
`endif
                        if (length == '0) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        acc        <= mult_out;
                        ovf_sticky <= ovf_sticky | mult_overflow;
                        count      <= count + LEN_W'(1);
                        if (count == len_q - LEN_W'(1)) begin
                            state        <= DONE;
                            in_ready     <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
`ifdef MAC_SEQ_STALL_CNT_EN
                    if (!in_valid && stall_count != 16'hFFFF)
                        stall_count <= stall_count + 16'd1;
`endif
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b0;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
